// File: rtl/axi4stream_beat_packer_if.sv
// AXI4-Stream bundle shared by the narrow input side and the wide packed output side.
// The slave view omits tkeep because the narrow beat stream carries no lane mask.
interface axi4stream_beat_packer_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    logic [KEEP_W-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi4stream_beat_packer.sv
// Packs BEATS narrow AXI4-Stream beats (or fewer, on tlast) into one wide word with a
// lane keep mask, presented on a backpressured master port; counts tlast words sent.
module axi4stream_beat_packer #(
    parameter int TDATA_W   = 8,
    parameter int BEATS     = 5,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axi4stream_beat_packer_if.slave   s,
    axi4stream_beat_packer_if.master  m,
    output logic [CNT_W-1:0]          pkt_count
);
    localparam int WORD_W = TDATA_W * BEATS;
    localparam int IDX_W  = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [WORD_W-1:0] acc_q, acc_d, acc_ins;
    logic [BEATS-1:0]  keep_q, keep_d, keep_ins;
    logic [IDX_W-1:0]  idx_q, idx_d, lane;
    logic [WORD_W-1:0] data_q, data_d;
    logic [BEATS-1:0]  mkeep_q, mkeep_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s_fire, m_fire, completing;

    // The output slot is free when empty or draining this cycle, so no word is ever lost.
    assign s.tready   = aresetn && (!valid_q || m.tready);
    assign s_fire     = s.tvalid && s.tready;
    assign m_fire     = valid_q && m.tready;
    assign completing = (idx_q == LAST_IDX) || s.tlast;
    assign lane       = (LSB_FIRST != 0) ? idx_q : LAST_IDX - idx_q;

    // Accumulator and keep mask with the current beat merged into its lane.
    always_comb begin
        acc_ins  = acc_q;
        keep_ins = keep_q;
        for (int i = 0; i < BEATS; i++) begin
            if (lane == IDX_W'(i)) begin
                acc_ins[i*TDATA_W +: TDATA_W] = s.tdata;
                keep_ins[i]                   = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
        acc_d   = acc_q;
        keep_d  = keep_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mkeep_d = mkeep_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (m_fire) begin
            valid_d = 1'b0;
            if (last_q) cnt_d = cnt_q + CNT_W'(1);
        end

        if (s_fire) begin
            if (completing) begin
                data_d  = acc_ins;
                mkeep_d = keep_ins;
                last_d  = s.tlast;
                valid_d = 1'b1;
                acc_d   = '0;
                keep_d  = '0;
                idx_d   = '0;
            end else begin
                acc_d  = acc_ins;
                keep_d = keep_ins;
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q   <= '0;
            keep_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            mkeep_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            keep_q  <= keep_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mkeep_q <= mkeep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m.tdata   = data_q;
    assign m.tkeep   = mkeep_q;
    assign m.tlast   = last_q;
    assign m.tvalid  = valid_q;
    assign pkt_count = cnt_q;
endmodule

// File: tb/tb_axi4stream_beat_packer.sv
// Self-checking bench: directed cases pinned by literal words plus a long randomized run
// compared every cycle against a queue-based packing model.
module tb_axi4stream_beat_packer;
    localparam int TW = 8;
    localparam int NB = 5;
    localparam int WW = TW * NB;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] pkt_count, pkt_count2;

    axi4stream_beat_packer_if #(.DATA_W(TW), .KEEP_W(1))  s_if();
    axi4stream_beat_packer_if #(.DATA_W(WW), .KEEP_W(NB)) m_if();
    axi4stream_beat_packer_if #(.DATA_W(TW), .KEEP_W(1))  s2_if();
    axi4stream_beat_packer_if #(.DATA_W(WW), .KEEP_W(NB)) m2_if();

    axi4stream_beat_packer #(.TDATA_W(TW), .BEATS(NB), .LSB_FIRST(1), .CNT_W(16)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .s(s_if), .m(m_if), .pkt_count(pkt_count)
    );
    axi4stream_beat_packer #(.TDATA_W(TW), .BEATS(NB), .LSB_FIRST(0), .CNT_W(16)) u_msb (
        .aclk(aclk), .aresetn(aresetn), .s(s2_if), .m(m2_if), .pkt_count(pkt_count2)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [WW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } word_t;

    int          errors = 0;
    int          checks = 0;
    word_t       exp_q[$];
    word_t       got_q[$];
    logic [TW-1:0] cur_beats[$];
    int          model_pkts = 0;
    bit          rnd_mode = 0;
    bit          ready_val = 1;
    bit          stall_q = 0;
    word_t       held;
    int          tlast_sent = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference packing: beat i goes to bits [8i+7:8i], keep bit i, unused lanes zero.
    function automatic word_t pack(input logic [TW-1:0] b[$], input bit last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        w.last = last;
        for (int i = 0; i < b.size(); i++) begin
            w.data = w.data | (WW'(b[i]) << (TW * i));
            w.keep = w.keep | NB'(1 << i);
        end
        return w;
    endfunction

    always @(negedge aclk) begin
        word_t e;
        if (!aresetn) begin
            cur_beats.delete();
            exp_q.delete();
            model_pkts = 0;
            stall_q = 0;
        end else begin
            check(m_if.tvalid == (exp_q.size() != 0), "m_tvalid", 64'(m_if.tvalid), 64'(exp_q.size() != 0));
            check(s_if.tready == (!m_if.tvalid || m_if.tready), "s_tready", 64'(s_if.tready),
                  64'(!m_if.tvalid || m_if.tready));
            check(pkt_count == 16'(model_pkts), "pkt_count", 64'(pkt_count), 64'(model_pkts));
            if (stall_q)
                check(m_if.tvalid && m_if.tdata == held.data && m_if.tkeep == held.keep && m_if.tlast == held.last,
                      "hold_stable", 64'(m_if.tdata), 64'(held.data));
            if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(m_if.tdata == e.data, "m_tdata", 64'(m_if.tdata), 64'(e.data));
                check(m_if.tkeep == e.keep, "m_tkeep", 64'(m_if.tkeep), 64'(e.keep));
                check(m_if.tlast == e.last, "m_tlast", 64'(m_if.tlast), 64'(e.last));
                got_q.push_back('{m_if.tdata, m_if.tkeep, m_if.tlast});
                if (e.last) model_pkts++;
            end
            stall_q = m_if.tvalid && !m_if.tready;
            held = '{m_if.tdata, m_if.tkeep, m_if.tlast};
            if (s_if.tvalid && s_if.tready) begin
                cur_beats.push_back(s_if.tdata);
                if (cur_beats.size() == NB || s_if.tlast) begin
                    exp_q.push_back(pack(cur_beats, s_if.tlast));
                    cur_beats.delete();
                end
            end
        end
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_if.tready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    task automatic send(input logic [TW-1:0] d, input bit l);
        int  n;
        bit  accepted;
        n = 0;
        accepted = 0;
        s_if.tdata = d;
        s_if.tlast = l;
        s_if.tvalid = 1'b1;
        while (!accepted && n < 200) begin
            @(negedge aclk);
            n++;
            accepted = s_if.tready;
            @(posedge aclk);
            #1;
        end
        if (!accepted) check(1'b0, "send_timeout", 64'(n), 64'(200));
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_val = 1;
        rnd_mode = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check(n < 100, "drain_timeout", 64'(n), 64'(100));
        check(cur_beats.size() == 0, "no_partial_left", 64'(cur_beats.size()), 64'(0));
        @(posedge aclk);
        #1;
    endtask

    task automatic check_word(input int i, input logic [WW-1:0] d, input logic [NB-1:0] k, input bit l,
                              input string name);
        if (got_q.size() <= i) begin
            check(1'b0, name, 64'(got_q.size()), 64'(i + 1));
        end else begin
            check(got_q[i].data == d, name, 64'(got_q[i].data), 64'(d));
            check(got_q[i].keep == k, name, 64'(got_q[i].keep), 64'(k));
            check(got_q[i].last == l, name, 64'(got_q[i].last), 64'(l));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [TW-1:0] t5[5];
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tkeep = '1;
        s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0; s2_if.tkeep = '1;
        m2_if.tready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check(m_if.tvalid == 1'b0, "rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        check(m_if.tdata == '0, "rst_m_tdata", 64'(m_if.tdata), 64'(0));
        check(m_if.tkeep == '0, "rst_m_tkeep", 64'(m_if.tkeep), 64'(0));
        check(m_if.tlast == 1'b0, "rst_m_tlast", 64'(m_if.tlast), 64'(0));
        check(pkt_count == 16'd0, "rst_pkt_count", 64'(pkt_count), 64'(0));
        check(s_if.tready == 1'b0, "rst_s_tready", 64'(s_if.tready), 64'(0));
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Full word, back-to-back, one cycle latency
        got_q.delete();
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'h11, 0); send(8'h22, 0);
        @(negedge aclk);
        check(m_if.tvalid == 1'b1, "t1_latency", 64'(m_if.tvalid), 64'(1));
        check(m_if.tdata == 40'h2211CCBBAA, "t1_data_now", 64'(m_if.tdata), 64'h2211CCBBAA);
        drain();
        check(got_q.size() == 1, "t1_count", 64'(got_q.size()), 64'(1));
        check_word(0, 40'h2211CCBBAA, 5'b11111, 1'b0, "t1_word");

        // Full word then a single-beat tlast word
        got_q.delete();
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        drain();
        check(got_q.size() == 2, "t2_count", 64'(got_q.size()), 64'(2));
        check_word(0, 40'h2211CCBBAA, 5'b11111, 1'b0, "t2_word0");
        check_word(1, 40'h0000000033, 5'b00001, 1'b1, "t2_word1");
        check(pkt_count == 16'd1, "t2_pkt_count", 64'(pkt_count), 64'(1));

        // Backpressure across two words
        @(negedge aclk);
        ready_val = 0;
        @(posedge aclk);
        #1;
        got_q.delete();
        fork
            for (int i = 0; i < 10; i++) send(8'(8'h11 + i), 0);
            begin
                repeat (12) @(negedge aclk);
                check(s_if.tready == 1'b0, "t3_s_tready_low", 64'(s_if.tready), 64'(0));
                check(m_if.tvalid == 1'b1, "t3_m_tvalid_held", 64'(m_if.tvalid), 64'(1));
                check(m_if.tdata == 40'h1514131211, "t3_data_held", 64'(m_if.tdata), 64'h1514131211);
                ready_val = 1;
            end
        join
        drain();
        check(got_q.size() == 2, "t3_count", 64'(got_q.size()), 64'(2));
        check_word(0, 40'h1514131211, 5'b11111, 1'b0, "t3_word0");
        check_word(1, 40'h1A19181716, 5'b11111, 1'b0, "t3_word1");

        // Mid-packet reset discards the partial word
        send(8'h55, 0); send(8'h66, 0);
        aresetn = 1'b0;
        #1;
        check(m_if.tvalid == 1'b0 && m_if.tdata == '0 && m_if.tkeep == '0 && m_if.tlast == 1'b0,
              "t4_rst_outputs", 64'(m_if.tdata), 64'(0));
        check(pkt_count == 16'd0, "t4_rst_pkt_count", 64'(pkt_count), 64'(0));
        check(s_if.tready == 1'b0, "t4_rst_s_tready", 64'(s_if.tready), 64'(0));
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        got_q.delete();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        drain();
        check(got_q.size() == 1, "t4_count", 64'(got_q.size()), 64'(1));
        check_word(0, 40'h0044332211, 5'b01111, 1'b1, "t4_word");
        check(pkt_count == 16'd1, "t4_pkt_count", 64'(pkt_count), 64'(1));

        // MSB-first lane order on the second instance
        t5 = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22};
        for (int i = 0; i < 5; i++) begin
            s2_if.tdata = t5[i];
            s2_if.tvalid = 1'b1;
            @(posedge aclk);
            #1;
        end
        s2_if.tvalid = 1'b0;
        @(negedge aclk);
        check(m2_if.tvalid == 1'b1, "t5_m_tvalid", 64'(m2_if.tvalid), 64'(1));
        check(m2_if.tdata == 40'hAABBCC1122, "t5_data", 64'(m2_if.tdata), 64'hAABBCC1122);
        check(m2_if.tkeep == 5'b11111, "t5_keep", 64'(m2_if.tkeep), 64'(5'b11111));
        check(m2_if.tlast == 1'b0, "t5_last", 64'(m2_if.tlast), 64'(0));
        @(posedge aclk);
        #1;

        // Randomized valid/ready/tlast against the packing model
        rnd_mode = 1;
        tlast_sent = 0;
        for (int i = 0; i < 1000; i++) begin
            bit l;
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
            l = (i == 999) || ($urandom_range(0, 6) == 0);
            if (l) tlast_sent++;
            send(8'($urandom), l);
        end
        drain();
        check(pkt_count == 16'(1 + tlast_sent), "t6_pkt_count", 64'(pkt_count), 64'(1 + tlast_sent));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
